// File: rtl/instr_mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// kgp_loader_pkg : shared definitions for the instruction-memory loader.
//   BYTE_W / WORD_W : load-stream byte width and instruction word width.
//   loader_state_e  : loader FSM state encodings. ST_CHK exists only when
//                     LOADER_CHECKSUM_EN is defined.
// ---------------------------------------------------------------------------
package kgp_loader_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      ST_LEN   = 3'd0,
      ST_DATA  = 3'd1,
      ST_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      ST_CHK   = 3'd3,
`endif
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } loader_state_e;

endpackage : kgp_loader_pkg

// File: rtl/instr_mem_loader_if.sv
// ---------------------------------------------------------------------------
// instr_mem_loader_if : byte load-stream handshake.
//   in_data  : stream byte (master -> slave)
//   in_valid : in_data valid (master -> slave)
//   in_ready : slave can accept; a byte moves on a rising edge with
//              in_valid && in_ready
// Modports: master = stream source, slave = loader.
// ---------------------------------------------------------------------------
interface instr_mem_loader_if;
   import kgp_loader_pkg::*;

   logic [BYTE_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (output in_data, output in_valid, input  in_ready);
   modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface : instr_mem_loader_if

// File: rtl/instr_mem_loader_packer.sv
// ---------------------------------------------------------------------------
// byte_word_packer : assembles four stream bytes (MSB first) into a word.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr_i        : drop any partial word and restart at byte 0
//   byte_valid_i : byte_i is consumed this cycle
//   byte_i       : incoming byte
//   word_o       : earlier three bytes concatenated with byte_i
//   word_done_o  : byte_i is the 4th byte; word_o is the complete word
// ---------------------------------------------------------------------------
module byte_word_packer
   import kgp_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              byte_valid_i,
   input  logic [BYTE_W-1:0] byte_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_done_o
);

   // Only the first three bytes need storage; the 4th is forwarded
   // combinationally so the word is available on the edge it arrives.
   logic [WORD_W-BYTE_W-1:0] word_q;
   logic [1:0]               idx_q;

   assign word_o      = {word_q, byte_i};
   assign word_done_o = byte_valid_i && (idx_q == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         idx_q  <= '0;
      end else if (clr_i) begin
         word_q <= '0;
         idx_q  <= '0;
      end else if (byte_valid_i) begin
         word_q <= word_o[WORD_W-BYTE_W-1:0];
         idx_q  <= idx_q + 2'd1;
      end
   end

endmodule : byte_word_packer

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader : loads N instruction words from a byte stream into
// instruction memory, holding the core in reset until the load completes.
// Stream: length byte N, then 4*N data bytes, MSB of each word first.
//   clk       : clock
//   rst       : asynchronous active-low reset
//   ld        : byte stream (instr_mem_loader_if.slave)
//   mem_we    : one-cycle memory write strobe
//   mem_addr  : memory word address
//   mem_wdata : instruction word
//   cpu_rst   : core reset, high until a successful load
//   done      : load completed (held until reset)
//   error     : load aborted (held until reset)
// Optional macro LOADER_CHECKSUM_EN: after the last word one more byte is
// accepted and compared with the XOR of all data bytes.
// ---------------------------------------------------------------------------
module instr_mem_loader
   import kgp_loader_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int MEM_DEPTH = 256
) (
   input  logic                clk,
   input  logic                rst,
   instr_mem_loader_if.slave   ld,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [WORD_W-1:0]   mem_wdata,
   output logic                cpu_rst,
   output logic                done,
   output logic                error
);

   loader_state_e     state_q, state_d;
   logic [BYTE_W-1:0] n_q,     n_d;
   logic [BYTE_W-1:0] cnt_q,   cnt_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] csum_q,  csum_d;
`endif

   logic              ready;
   logic              accept;
   logic              pk_clr;
   logic              pk_valid;
   logic [WORD_W-1:0] pk_word;
   logic              pk_word_done;

   byte_word_packer u_packer (
      .clk          (clk),
      .rst_n        (rst),
      .clr_i        (pk_clr),
      .byte_valid_i (pk_valid),
      .byte_i       (ld.in_data),
      .word_o       (pk_word),
      .word_done_o  (pk_word_done)
   );

   always_comb begin
      ready = 1'b0;
      case (state_q)
         ST_LEN, ST_DATA: ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         ST_CHK:          ready = 1'b1;
`endif
         default:         ready = 1'b0;
      endcase
   end

   assign accept      = ld.in_valid && ready;
   assign ld.in_ready = ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_LEN;
         n_q     <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d   = csum_q;
`endif
      pk_clr   = 1'b0;
      pk_valid = 1'b0;

      case (state_q)
         ST_LEN: begin
            // Packer is held clear while waiting for a length byte.
            pk_clr = 1'b1;
            if (accept) begin
               if ((ld.in_data == '0) || (int'(ld.in_data) > MEM_DEPTH)) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_DATA;
                  n_d     = ld.in_data;
                  cnt_d   = '0;
                  addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                  csum_d  = '0;
`endif
               end
            end
         end

         ST_DATA: begin
            if (accept) begin
               pk_valid = 1'b1;
`ifdef LOADER_CHECKSUM_EN
               csum_d   = csum_q ^ ld.in_data;
`endif
               if (pk_word_done) begin
                  wdata_d = pk_word;
                  cnt_d   = cnt_q + 1'b1;
                  state_d = ST_WRITE;
               end
            end
         end

         ST_WRITE: begin
            addr_d = addr_q + 1'b1;
            if (cnt_q == n_q) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = ST_CHK;
`else
               state_d = ST_DONE;
`endif
            end else begin
               state_d = ST_DATA;
            end
         end

`ifdef LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (accept) begin
               state_d = (ld.in_data == csum_q) ? ST_DONE : ST_ERR;
            end
         end
`endif

         ST_DONE: state_d = ST_DONE;
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_ERR;
      endcase
   end

   assign mem_we    = (state_q == ST_WRITE);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign done      = (state_q == ST_DONE);
   assign error     = (state_q == ST_ERR);
   assign cpu_rst   = (state_q != ST_DONE);

endmodule : instr_mem_loader

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-002 Parameter MEM_DEPTH, default 256, number of writable instruction words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  8  load-stream byte.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader can accept a byte; a byte transfers on a rising edge with in_valid && in_ready.
REQ-008 mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 mem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 mem_wdata  output  32  instruction word to write.
REQ-011 cpu_rst  output  1  active-high reset to the processor core; held high until the load completes.
REQ-012 done  output  1  load completed successfully.
REQ-013 error  output  1  load aborted; sticky.

Function
REQ-014 The stream SHALL be: a length byte N (instruction count), then 4*N data bytes, with the most significant byte of each word first.
REQ-015 The FSM SHALL use these states: LEN (await N), DATA (collect bytes), WRITE (issue write), CHK (checksum, macro only), DONE, ERR.
REQ-016 in_ready SHALL be 1 in LEN, DATA and CHK, and 0 in WRITE, DONE and ERR.
REQ-017 In LEN, N=0 or N>MEM_DEPTH SHALL go to ERR; otherwise the loader SHALL go to DATA with word counter=0 and mem_addr=0.
REQ-018 After the 4th byte of a word, the loader SHALL enter WRITE on the next edge, with mem_we=1 and mem_addr/mem_wdata valid for exactly that one cycle; latency from the 4th byte to mem_we is 1 cycle.
REQ-019 On leaving WRITE, mem_addr SHALL increment; if the counter reached N, the next state SHALL be DONE (or CHK with the macro), else DATA.
REQ-020 Gaps in in_valid SHALL stall without data loss; the partial-word byte index SHALL be kept.
REQ-021 In DONE: done=1 and cpu_rst=0 from the first DONE cycle, held until reset; further bytes are ignored.
REQ-022 In ERR: error=1, cpu_rst=1 and done=0, held until reset; mem_we SHALL never assert in ERR.
REQ-023 mem_we SHALL be 0 in every state except WRITE.

Reset
REQ-024 On rst=0 the block SHALL enter LEN, with in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, error=0.
REQ-025 Reset mid-load SHALL discard partial words and counters; memory already written is not cleared.

Configuration
REQ-026 Macro LOADER_CHECKSUM_EN defined: after the last WRITE, the loader SHALL go to CHK, accept one byte, and compare it with the XOR of all 4*N data bytes; a match SHALL go to DONE, a mismatch SHALL go to ERR.
REQ-027 LOADER_CHECKSUM_EN undefined: there SHALL be no CHK state and no checksum register, and the last WRITE SHALL go directly to DONE.

Structure
REQ-028 The shared package kgp_loader_pkg SHALL hold the state encodings, BYTE_W=8 and WORD_W=32.
REQ-029 Byte-to-word assembly (shift register plus 2-bit byte index) SHALL be a sub-module named byte_word_packer; the FSM, counters and checksum SHALL stay in instr_mem_loader.

Verification
REQ-030 Reset: rst=0 -> in_ready=1, mem_we=0, cpu_rst=1, done=0, error=0.
REQ-031 Stream 01,12,34,56,78 -> one mem_we pulse with addr 0 and wdata 0x12345678; next cycle done=1 and cpu_rst=0.
REQ-032 N=2 with one-cycle in_valid gaps -> writes at addr 0 and 1 with correct words; in_ready=0 during each WRITE cycle.
REQ-033 N=0 -> error=1, cpu_rst=1, no mem_we; later bytes ignored.
REQ-034 Reset after 2 data bytes, then stream 01,AA,BB,CC,DD -> single write at addr 0 with 0xAABBCCDD.
REQ-035 LOADER_CHECKSUM_EN: 01,01,02,03,04 then 04 -> done=1; checksum byte 05 instead -> error=1, cpu_rst=1.
